// File: rtl/ddr_req_seq.sv
// ddr_req_seq: turns one client line request into DDR2 write/read strobes,
// with a per-phase wait timeout and a held single-entry response.
module ddr_req_seq #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 4095
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_raddr,
  input  logic [ADDR_W-1:0] req_waddr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              ddr_we,
  output logic              ddr_re,
  output logic [ADDR_W-1:0] ddr_addr,
  output logic [DATA_W-1:0] ddr_wdata,
  input  logic [DATA_W-1:0] ddr_rdata,
  input  logic              ddr_wend,
  input  logic              ddr_rend,
  output logic [2:0]        state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    WR_REL = 3'd2,
    RD     = 3'd3,
    RD_REL = 3'd4,
    RESP   = 3'd5
  } st_e;

  st_e               st_q;
  logic              rdy_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] ra_q;
  logic [ADDR_W-1:0] wa_q;
  logic [DATA_W-1:0] wd_q;
  logic [DATA_W-1:0] rd_q;
  logic              err_q;
  logic [CW-1:0]     cnt_q;
  logic              tmo;

  assign tmo = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q  <= IDLE;
      rdy_q <= 1'b0;
      op_q  <= '0;
      ra_q  <= '0;
      wa_q  <= '0;
      wd_q  <= '0;
      rd_q  <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      unique case (st_q)
        IDLE: begin
          if (req_valid && rdy_q) begin
            rdy_q <= 1'b0;
            op_q  <= req_op;
            ra_q  <= req_raddr;
            wa_q  <= req_waddr;
            wd_q  <= req_wdata;
            rd_q  <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
            unique case (1'b1)
              req_op == 2'b00: st_q <= RD;
              req_op == 2'b01: st_q <= WR;
              req_op == 2'b10: st_q <= WR;
              req_op == 2'b11: begin
                st_q  <= RESP;
                err_q <= 1'b1;
              end
            endcase
          end else begin
            rdy_q <= 1'b1;
          end
        end
        WR: begin
          if (ddr_wend) begin
            st_q  <= WR_REL;
            cnt_q <= '0;
          end else if (tmo) begin
            st_q  <= RESP;
            err_q <= 1'b1;
          end
        end
        WR_REL: begin
          if (!ddr_wend) begin
            if (op_q == 2'b10) begin
              st_q  <= RD;
              cnt_q <= '0;
            end else begin
              st_q <= RESP;
            end
          end else if (tmo) begin
            st_q  <= RESP;
            err_q <= 1'b1;
          end
        end
        RD: begin
          if (ddr_rend) begin
            st_q  <= RD_REL;
            cnt_q <= '0;
            rd_q  <= ddr_rdata;
          end else if (tmo) begin
            st_q  <= RESP;
            err_q <= 1'b1;
          end
        end
        RD_REL: begin
          if (!ddr_rend) begin
            st_q <= RESP;
          end else if (tmo) begin
            // an errored response never carries read data
            st_q  <= RESP;
            err_q <= 1'b1;
            rd_q  <= '0;
          end
        end
        RESP: begin
          if (resp_ready) begin
            st_q  <= IDLE;
            rdy_q <= 1'b1;
          end
        end
        default: begin
          st_q  <= IDLE;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end

  assign state      = st_q;
  assign req_ready  = rdy_q;
  assign ddr_we     = (st_q == WR);
  assign ddr_re     = (st_q == RD);
  assign ddr_wdata  = wd_q;
  assign resp_valid = (st_q == RESP);
  assign resp_rdata = rd_q;
  assign resp_err   = err_q;

  assign ddr_addr = (st_q == WR || st_q == WR_REL) ? wa_q :
                    (st_q == RD || st_q == RD_REL) ? ra_q : '0;

endmodule

// File: tb/tb_ddr_req_seq.sv
// tb_ddr_req_seq: randomized transactions against a DDR stub and a
// transaction-level reference model, plus directed latency/timeout/reset cases.
module tb_ddr_req_seq;

  localparam int AW  = 24;
  localparam int DW  = 128;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = '0;
  logic [AW-1:0] req_raddr = '0;
  logic [AW-1:0] req_waddr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          ddr_we;
  logic          ddr_re;
  logic [AW-1:0] ddr_addr;
  logic [DW-1:0] ddr_wdata;
  logic [DW-1:0] ddr_rdata = '0;
  logic          ddr_wend = 1'b0;
  logic          ddr_rend = 1'b0;
  logic [2:0]    state;

  ddr_req_seq #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_raddr(req_raddr), .req_waddr(req_waddr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ddr_we(ddr_we), .ddr_re(ddr_re), .ddr_addr(ddr_addr),
    .ddr_wdata(ddr_wdata), .ddr_rdata(ddr_rdata),
    .ddr_wend(ddr_wend), .ddr_rend(ddr_rend), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // DDR stub configuration and storage
  int rdly = 1, wdly = 1, rwid = 1, wwid = 1;
  bit rstuck = 0, wstuck = 0;
  logic [DW-1:0] ddr_mem [int];
  logic [DW-1:0] ref_mem [int];

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return {4{{8'h3C, a} ^ 32'h0F0F0F0F}};
  endfunction

  function automatic logic [DW-1:0] ddr_get(input logic [AW-1:0] a);
    return ddr_mem.exists(int'(a)) ? ddr_mem[int'(a)] : dflt(a);
  endfunction

  function automatic logic [DW-1:0] ref_get(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
  endfunction

  initial begin : ddr_read_stub
    logic [AW-1:0] a;
    forever begin
      @(posedge clk);
      if (ddr_re === 1'b1 && !rstuck) begin
        a = ddr_addr;
        repeat (rdly - 1) @(posedge clk);
        ddr_rdata <= ddr_get(a);
        ddr_rend  <= 1'b1;
        repeat (rwid) @(posedge clk);
        ddr_rend  <= 1'b0;
        while (ddr_re === 1'b1) @(posedge clk);
      end
    end
  end

  initial begin : ddr_write_stub
    forever begin
      @(posedge clk);
      if (ddr_we === 1'b1 && !wstuck) begin
        ddr_mem[int'(ddr_addr)] = ddr_wdata;
        repeat (wdly - 1) @(posedge clk);
        ddr_wend <= 1'b1;
        repeat (wwid) @(posedge clk);
        ddr_wend <= 1'b0;
        while (ddr_we === 1'b1) @(posedge clk);
      end
    end
  end

  // current transaction as seen by the reference model
  bit            chk_on = 0;
  bit            busy = 0;
  logic [AW-1:0] cur_ra, cur_wa;
  logic [DW-1:0] cur_wd;
  logic [DW-1:0] exp_rd;
  bit            exp_err;
  int            exp_we, exp_re;
  int            acc_cyc;
  int            we_cyc, re_cyc, we_rise, re_rise;
  int            first_we, first_re, first_rv;
  bit            we_prev = 0, re_prev = 0;
  logic [DW-1:0] rsp_rd;
  bit            rsp_err;

  always @(negedge clk) begin
    if (chk_on) begin
      chki("req_ready", int'(req_ready), int'(!busy));
      chki("strobe_excl", int'(ddr_we & ddr_re), 0);
      if (!busy) begin
        chki("idle_state", int'(state), 0);
        chki("idle_resp_valid", int'(resp_valid), 0);
        chki("idle_strobes", int'(ddr_we | ddr_re), 0);
      end else begin
        chk("wdata_hold", ddr_wdata, cur_wd);
        if (ddr_we) chk("we_addr", DW'(ddr_addr), DW'(cur_wa));
        if (ddr_re) chk("re_addr", DW'(ddr_addr), DW'(cur_ra));
        if (resp_valid) begin
          chk("resp_rdata", resp_rdata, exp_rd);
          chki("resp_err", int'(resp_err), int'(exp_err));
        end
      end
      if (!ddr_we && !ddr_re && (!busy || resp_valid))
        chk("addr_zero", DW'(ddr_addr), '0);
      if (ddr_we) we_cyc++;
      if (ddr_re) re_cyc++;
      if (ddr_we && !we_prev) begin
        we_rise++;
        if (first_we < 0) first_we = cyc;
      end
      if (ddr_re && !re_prev) begin
        re_rise++;
        if (first_re < 0) first_re = cyc;
      end
      if (resp_valid && first_rv < 0) first_rv = cyc;
    end
    we_prev = ddr_we;
    re_prev = ddr_re;
  end

  task automatic do_txn(input logic [1:0] op, input logic [AW-1:0] ra,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input int hold);
    int n;
    bit wr, rd;
    wr = (op == 2'd1) || (op == 2'd2);
    rd = (op == 2'd0) || (op == 2'd2 && !wstuck);
    exp_err = (op == 2'd3) || (wr && wstuck) || (rd && rstuck);
    if (wr && !wstuck) ref_mem[int'(wa)] = wd;
    exp_rd = (rd && !exp_err) ? ref_get(ra) : '0;
    exp_we = wr ? 1 : 0;
    exp_re = rd ? 1 : 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_raddr = ra;
    req_waddr = wa;
    req_wdata = wd;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chki("accept_bound", int'(n < 50), 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 2'($urandom);
    req_raddr = AW'($urandom);
    req_waddr = AW'($urandom);
    req_wdata = {$urandom, $urandom, $urandom, $urandom};
    cur_ra = ra;
    cur_wa = wa;
    cur_wd = wd;
    acc_cyc = cyc;
    we_cyc = 0; re_cyc = 0; we_rise = 0; re_rise = 0;
    first_we = -1; first_re = -1; first_rv = -1;
    busy = 1;
    n = 0;
    while (resp_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chki("resp_bound", int'(n < 60), 1);
    if (hold > 0) begin
      req_valid = 1'b1;
      req_op = 2'd3;
      repeat (hold) @(negedge clk);
    end
    rsp_rd = resp_rdata;
    rsp_err = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    req_valid = 1'b0;
    busy = 0;
    chki("we_pulses", we_rise, exp_we);
    chki("re_pulses", re_rise, exp_re);
  endtask

  initial begin
    // reset held from time zero
    #12;
    chki("rst_ready", int'(req_ready), 0);
    chki("rst_state", int'(state), 0);
    chki("rst_strobes", int'(ddr_we | ddr_re), 0);
    chk("rst_addr", DW'(ddr_addr), '0);
    chki("rst_valid", int'(resp_valid), 0);
    chk("rst_rdata", resp_rdata, '0);
    chki("rst_err", int'(resp_err), 0);
    chk("rst_wdata", ddr_wdata, '0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chki("rel_ready_pre_edge", int'(req_ready), 0);
    @(posedge clk);
    #1;
    chki("rel_ready_post_edge", int'(req_ready), 1);
    chk_on = 1;

    // plain read with one-cycle done pulse
    ddr_mem[16] = {16{8'hA5}};
    ref_mem[16] = {16{8'hA5}};
    do_txn(2'd0, 24'h000010, 24'h0, '0, 0);
    chk("rd_a5_data", rsp_rd, {16{8'hA5}});
    chki("rd_a5_err", int'(rsp_err), 0);
    chki("rd_re_latency", first_re - acc_cyc, 0);
    chki("rd_rv_latency", first_rv - acc_cyc, 3);

    // write then read, distinct lines
    do_txn(2'd2, 24'h000030, 24'h000020, '1, 0);
    chki("wr_before_rd", int'(first_we < first_re), 1);
    chk("wrrd_data", rsp_rd, dflt(24'h000030));
    chk("ddr_line_20", ddr_get(24'h000020), '1);

    // write then read of the same line returns the new data
    do_txn(2'd2, 24'h000040, 24'h000040, {4{32'hDEADBEEF}}, 0);
    chk("wrrd_same_line", rsp_rd, {4{32'hDEADBEEF}});

    // write-only response carries no data
    do_txn(2'd1, 24'h0, 24'h000050, {4{32'h12345678}}, 0);
    chk("wr_only_data", rsp_rd, '0);

    // write timeout with done flag stuck low
    wstuck = 1;
    do_txn(2'd1, 24'h0, 24'h000060, {4{32'h0BADF00D}}, 0);
    chki("wr_tmo_cycles", we_cyc, 8);
    chki("wr_tmo_err", int'(rsp_err), 1);
    chk("wr_tmo_data", rsp_rd, '0);
    do_txn(2'd2, 24'h000010, 24'h000060, {4{32'h0BADF00D}}, 0);
    chki("wrrd_tmo_no_read", re_cyc, 0);
    chki("wrrd_tmo_err", int'(rsp_err), 1);
    wstuck = 0;

    // read timeout
    rstuck = 1;
    do_txn(2'd0, 24'h000010, 24'h0, '0, 0);
    chki("rd_tmo_cycles", re_cyc, 8);
    chk("rd_tmo_data", rsp_rd, '0);
    rstuck = 0;

    // illegal op
    do_txn(2'd3, 24'h000010, 24'h000010, '1, 0);
    chki("ill_rv_latency", first_rv - acc_cyc, 0);
    chki("ill_err", int'(rsp_err), 1);
    chki("ill_strobes", we_cyc + re_cyc, 0);

    // response backpressure with a request pending
    do_txn(2'd0, 24'h000010, 24'h0, '0, 5);
    chk("bp_data", rsp_rd, {16{8'hA5}});

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      rdly = $urandom_range(1, 3);
      wdly = $urandom_range(1, 3);
      rwid = $urandom_range(1, 2);
      wwid = $urandom_range(1, 2);
      do_txn(2'($urandom_range(0, 3)), AW'($urandom_range(0, 15)),
             AW'($urandom_range(0, 15)),
             {$urandom, $urandom, $urandom, $urandom},
             $urandom_range(0, 2));
    end

    // asynchronous reset while the read strobe is high
    rdly = 3;
    rwid = 1;
    wdly = 1;
    wwid = 1;
    chk_on = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 2'd0;
    req_raddr = 24'h000044;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (ddr_re !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chki("mid_re_seen", int'(ddr_re), 1);
    end
    reset = 1'b0;
    #1;
    chki("mid_rst_re", int'(ddr_re), 0);
    chki("mid_rst_valid", int'(resp_valid), 0);
    chki("mid_rst_state", int'(state), 0);
    chki("mid_rst_ready", int'(req_ready), 0);
    chk("mid_rst_addr", DW'(ddr_addr), '0);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chki("mid_rel_ready", int'(req_ready), 1);
    chki("mid_rel_idle", int'(ddr_we | ddr_re), 0);
    chk_on = 1;
    rdly = 1;
    do_txn(2'd0, 24'h000044, 24'h0, '0, 0);
    chk("post_rst_read", rsp_rd, dflt(24'h000044));
    chki("post_rst_err", int'(rsp_err), 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
